// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter: round-robin sharing of one SPI byte engine among NUM_REQ requesters (req/tx in, ack/done/err/rx out, m_* to master, cs_sel one-hot select, watchdog on WAIT)
module spi_req_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DW          = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DW-1:0]      req_tx_data,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [NUM_REQ-1:0]         req_done,
  output logic [NUM_REQ-1:0]         req_err,
  output logic [DW-1:0]              rsp_rx_data,
  output logic                       arb_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [NUM_REQ-1:0]         cs_sel,
  output logic                       m_start,
  output logic [DW-1:0]              m_tx_data,
  input  logic                       m_busy,
  input  logic                       m_done,
  input  logic [DW-1:0]              m_rx_data
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] rr_ptr, pick;
  logic [CW-1:0] wd_q;
  logic [DW-1:0] rx_q;
  logic [NUM_REQ-1:0] g_oh;
  logic err_q, go, wd_hit, wait_exit;
  assign go        = |req && !m_busy;
  assign wd_hit    = (TIMEOUT_CYC != 0) && (wd_q == CW'(TIMEOUT_CYC - 1));
  assign wait_exit = m_done || wd_hit;
  assign g_oh      = NUM_REQ'(1) << grant_id;
  always_comb begin
    pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[(int'(rr_ptr) + i) % NUM_REQ]) pick = GW'((int'(rr_ptr) + i) % NUM_REQ);
  end
  always_comb begin
    state_d     = (state_q == IDLE)  ? (go ? ISSUE : IDLE) :
                  (state_q == ISSUE) ? WAIT :
                  (state_q == WAIT)  ? (wait_exit ? RESP : WAIT) : IDLE;
    m_start     = state_q == ISSUE;
    arb_busy    = state_q != IDLE;
    req_ack     = m_start ? g_oh : '0;
    req_done    = (state_q == RESP) ? g_oh : '0;
    req_err     = (state_q == RESP && err_q) ? g_oh : '0;
    rsp_rx_data = (state_q == RESP) ? rx_q : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      cs_sel    <= '0;
      m_tx_data <= '0;
      wd_q      <= '0;
      err_q     <= 1'b0;
      rx_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && go) begin
        grant_id  <= pick;
        m_tx_data <= req_tx_data[pick*DW +: DW];
        cs_sel    <= NUM_REQ'(1) << pick;
      end
      if (state_q == ISSUE) begin
        rr_ptr <= (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        wd_q   <= '0;
        err_q  <= 1'b0;
      end
      if (state_q == WAIT) begin
        wd_q <= wd_q + 1'b1;
        if (wait_exit) begin
          cs_sel <= '0;
          rx_q   <= m_done ? m_rx_data : '0;
          err_q  <= !m_done;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb_spi_req_arbiter: directed checks of arbitration, fairness, busy hold-off, watchdog and reset
module tb_spi_req_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] req = '0, req_ack, req_done, req_err, cs_sel;
  logic [31:0] req_tx_data = '0;
  logic [7:0] rsp_rx_data, m_tx_data, m_rx_data = '0;
  logic arb_busy, m_start, m_busy = 1'b0, m_done = 1'b0;
  logic [1:0] grant_id;
  int tests = 0, fails = 0;
  spi_req_arbiter #(.NUM_REQ(4), .DW(8), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_tx_data(req_tx_data),
    .req_ack(req_ack), .req_done(req_done), .req_err(req_err),
    .rsp_rx_data(rsp_rx_data), .arb_busy(arb_busy), .grant_id(grant_id),
    .cs_sel(cs_sel), .m_start(m_start), .m_tx_data(m_tx_data),
    .m_busy(m_busy), .m_done(m_done), .m_rx_data(m_rx_data)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, 32'(arb_busy), 0);
    chk({tag, "_cs"}, 32'(cs_sel), 0);
    chk({tag, "_start"}, 32'(m_start), 0);
    chk({tag, "_ack"}, 32'(req_ack), 0);
    chk({tag, "_done"}, 32'(req_done), 0);
    chk({tag, "_err"}, 32'(req_err), 0);
    chk({tag, "_rx"}, 32'(rsp_rx_data), 0);
  endtask
  task automatic xfer(input string tag, input int g, input logic [7:0] rx);
    step();
    chk({tag, "_gid"}, 32'(grant_id), 32'(g));
    chk({tag, "_start"}, 32'(m_start), 1);
    chk({tag, "_ack"}, 32'(req_ack), 32'(1) << g);
    step();
    chk({tag, "_start_off"}, 32'(m_start), 0);
    m_done = 1'b1;
    m_rx_data = rx;
    step();
    m_done = 1'b0;
    chk({tag, "_done"}, 32'(req_done), 32'(1) << g);
    chk({tag, "_rx"}, 32'(rsp_rx_data), 32'(rx));
    chk({tag, "_err"}, 32'(req_err), 0);
    step();
  endtask
  initial begin
    step();
    step();
    chk_quiet("reset");
    chk("reset_gid", 32'(grant_id), 0);
    chk("reset_tx", 32'(m_tx_data), 0);
    rst_n = 1'b1;
    req = 4'b0010;
    req_tx_data = 32'h0000_A500;
    step();
    chk("single_start", 32'(m_start), 1);
    chk("single_ack", 32'(req_ack), 32'b0010);
    chk("single_cs", 32'(cs_sel), 32'b0010);
    chk("single_tx", 32'(m_tx_data), 32'hA5);
    chk("single_gid", 32'(grant_id), 1);
    chk("single_abusy", 32'(arb_busy), 1);
    req = 4'b0000;
    req_tx_data = 32'h0000_FF00;
    step();
    chk("single_start_off", 32'(m_start), 0);
    chk("single_cs_wait", 32'(cs_sel), 32'b0010);
    chk("single_tx_hold", 32'(m_tx_data), 32'hA5);
    for (int i = 0; i < 9; i++) step();
    chk("single_nodone", 32'(req_done), 0);
    m_done = 1'b1;
    m_rx_data = 8'h3C;
    step();
    m_done = 1'b0;
    chk("single_done", 32'(req_done), 32'b0010);
    chk("single_rx", 32'(rsp_rx_data), 32'h3C);
    chk("single_err", 32'(req_err), 0);
    chk("single_cs_resp", 32'(cs_sel), 0);
    step();
    chk_quiet("single_idle");
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 8; i++) xfer("fair", i % 4, 8'(8'h10 + i));
    req = 4'b0100;
    xfer("wrap_a", 2, 8'h21);
    req = 4'b0011;
    xfer("wrap_b", 0, 8'h22);
    xfer("wrap_c", 1, 8'h23);
    req = 4'b0000;
    m_busy = 1'b1;
    req = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("busy_nostart", 32'(m_start), 0);
      chk("busy_abusy", 32'(arb_busy), 0);
    end
    m_busy = 1'b0;
    xfer("busy_go", 3, 8'h77);
    req = 4'b0001;
    req_tx_data = 32'h0000_0011;
    m_rx_data = 8'h5A;
    step();
    chk("to_gid", 32'(grant_id), 0);
    req = 4'b0000;
    step();
    for (int i = 0; i < 15; i++) step();
    chk("to_still_wait", 32'(cs_sel), 32'b0001);
    chk("to_nodone", 32'(req_done), 0);
    step();
    chk("to_done", 32'(req_done), 32'b0001);
    chk("to_err", 32'(req_err), 32'b0001);
    chk("to_rx", 32'(rsp_rx_data), 0);
    step();
    req = 4'b0001;
    step();
    req = 4'b0000;
    step();
    for (int i = 0; i < 15; i++) step();
    m_done = 1'b1;
    m_rx_data = 8'hC3;
    step();
    m_done = 1'b0;
    chk("edge_done", 32'(req_done), 32'b0001);
    chk("edge_err", 32'(req_err), 0);
    chk("edge_rx", 32'(rsp_rx_data), 32'hC3);
    step();
    m_done = 1'b1;
    step();
    m_done = 1'b0;
    chk_quiet("stray_done");
    req = 4'b0100;
    step();
    chk("rst_gid", 32'(grant_id), 2);
    req = 4'b0000;
    step();
    step();
    rst_n = 1'b0;
    step();
    chk_quiet("rst_mid");
    chk("rst_mid_gid", 32'(grant_id), 0);
    chk("rst_mid_tx", 32'(m_tx_data), 0);
    rst_n = 1'b1;
    m_done = 1'b1;
    step();
    m_done = 1'b0;
    chk("rst_no_done", 32'(req_done), 0);
    req = 4'b1111;
    xfer("rst_next", 0, 8'h99);
    req = 4'b0000;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
